line_buffer_scaler: RTL and testbench

- Sits directly downstream of the VGA video timing block and upstream of the DAC/palette output stage.
- Holds two 256-pixel line banks in ping-pong: the VDP renderer fills one bank while the other is scanned out.
- Each pixel is shown 2x horizontally and each line on two scanlines, giving a 512x480 active image centred in 704 or 640 columns with a border colour round it.
- Issues per-line render requests to the renderer and delays sync/blank so they line up with pixel data.

---
 rtl/line_buffer_scaler_pkg.sv | 21 ++
 rtl/line_buffer_scaler_dpram.sv | 27 ++
 rtl/line_buffer_scaler.sv | 119 +++++++++++
 tb/tb_line_buffer_scaler.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_buffer_scaler_pkg.sv
// Shared line/window constants for the video timing and line-buffer path.
package line_buffer_scaler_pkg;

   localparam int         PIXW        = 6;
   localparam int         LINE_PIXELS = 256;
   localparam logic [8:0] VIS_LINES   = 9'd240;
   localparam logic [8:0] TOTAL_LINES = 9'd262;
   localparam logic [9:0] HSTART_704  = 10'd96;
   localparam logic [9:0] HSTART_640  = 10'd64;
   localparam logic [9:0] ACT_W       = 10'd512;

   typedef logic [PIXW-1:0] pix_t;

   // Source line the renderer must produce next: two lines ahead of display, wrapped.
   function automatic logic [8:0] render_target(input logic [8:0] line);
      logic [8:0] t;
      t = line + 9'd2;
      return (t >= TOTAL_LINES) ? t - TOTAL_LINES : t;
   endfunction

endpackage

// File: rtl/line_buffer_scaler_dpram.sv
// Simple dual-port line RAM: one write port, one read port with registered address.
module linebuf_dpram
   import line_buffer_scaler_pkg::*;
#(
   parameter int AW = 9
) (
   input  logic          clk,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  pix_t          wr_data_i,
   input  logic [AW-1:0] rd_addr_i,
   output pix_t          rd_data_o
);

   pix_t          mem_q [2**AW];
   logic [AW-1:0] rd_addr_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      rd_addr_q <= rd_addr_i;
   end

   assign rd_data_o = mem_q[rd_addr_q];

endmodule

// File: rtl/line_buffer_scaler.sv
// Ping-pong line buffer with 2x horizontal/vertical scaling, border fill and
// 2-clock sync/blank alignment between the timing block and the DAC stage.
module line_buffer_scaler
   import line_buffer_scaler_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       mode,
   input  logic [9:0] hpos,
   input  logic       hsync,
   input  logic       vsync,
   input  logic       blank,
   input  logic       vnext,
   input  logic       vnewframe,
   input  pix_t       border_color,
   input  logic       wr_en,
   input  logic [7:0] wr_idx,
   input  pix_t       wr_data,
   output logic       render_start,
   output logic [7:0] render_line,
   output pix_t       vid_data,
   output logic       vid_hsync,
   output logic       vid_vsync,
   output logic       vid_blank
);

   logic       wrbank_q;
   logic       mode_q;
   logic [8:0] line_q;
   logic       render_start_q;
   logic [7:0] render_line_q;

   logic [8:0] tgt_d;
   logic [9:0] hs_d;
   logic [9:0] rel_d;
   logic       borrow_d;
   logic       act_d;
   logic [8:0] rd_addr_d;
   pix_t       rd_data;

   assign tgt_d = render_target(line_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         line_q         <= '0;
         wrbank_q       <= 1'b0;
         mode_q         <= 1'b0;
         render_start_q <= 1'b0;
         render_line_q  <= '0;
      end else begin
         render_start_q <= 1'b0;
         if (vnewframe) begin
            line_q <= VIS_LINES;
         end else if (vnext) begin
            line_q <= (line_q == TOTAL_LINES - 9'd1) ? '0 : line_q + 9'd1;
         end
         if (vnext) begin
            wrbank_q <= ~wrbank_q;
            mode_q   <= mode;
            if (tgt_d < VIS_LINES) begin
               render_start_q <= 1'b1;
               render_line_q  <= tgt_d[7:0];
            end
         end
      end
   end

   // Window start only follows the mode latched at vnext, so a line is never split.
   assign hs_d              = mode_q ? HSTART_640 : HSTART_704;
   assign {borrow_d, rel_d} = {1'b0, hpos} - {1'b0, hs_d};
   assign act_d             = !borrow_d && (rel_d < ACT_W);
   assign rd_addr_d         = {~wrbank_q, rel_d[8:1]};

   linebuf_dpram #(.AW(9)) u_ram (
      .clk       (clk),
      .wr_en_i   (wr_en),
      .wr_addr_i ({wrbank_q, wr_idx}),
      .wr_data_i (wr_data),
      .rd_addr_i (rd_addr_d),
      .rd_data_o (rd_data)
   );

   logic act1_q, blank1_q, hsync1_q, vsync1_q;
   pix_t border1_q;
   pix_t data2_q;
   logic blank2_q, hsync2_q, vsync2_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         act1_q    <= 1'b0;
         blank1_q  <= 1'b1;
         hsync1_q  <= 1'b1;
         vsync1_q  <= 1'b1;
         border1_q <= '0;
         data2_q   <= '0;
         blank2_q  <= 1'b1;
         hsync2_q  <= 1'b1;
         vsync2_q  <= 1'b1;
      end else begin
         act1_q    <= act_d;
         blank1_q  <= blank;
         hsync1_q  <= hsync;
         vsync1_q  <= vsync;
         border1_q <= border_color;
         data2_q   <= blank1_q ? '0 : (act1_q ? rd_data : border1_q);
         blank2_q  <= blank1_q;
         hsync2_q  <= hsync1_q;
         vsync2_q  <= vsync1_q;
      end
   end

   assign render_start = render_start_q;
   assign render_line  = render_line_q;
   assign vid_data     = data2_q;
   assign vid_hsync    = hsync2_q;
   assign vid_vsync    = vsync2_q;
   assign vid_blank    = blank2_q;

endmodule

// File: tb/tb_line_buffer_scaler.sv
// Bench for line_buffer_scaler: frame-level reference model plus directed line scenarios.
module tb_line_buffer_scaler;

   logic       clk = 1'b0;
   logic       reset, mode, hsync, vsync, blank, vnext, vnewframe, wr_en;
   logic [9:0] hpos;
   logic [5:0] border_color, wr_data;
   logic [7:0] wr_idx;
   logic       render_start, vid_hsync, vid_vsync, vid_blank;
   logic [7:0] render_line;
   logic [5:0] vid_data;

   always #5 clk = ~clk;

   line_buffer_scaler dut (
      .clk          (clk),
      .reset        (reset),
      .mode         (mode),
      .hpos         (hpos),
      .hsync        (hsync),
      .vsync        (vsync),
      .blank        (blank),
      .vnext        (vnext),
      .vnewframe    (vnewframe),
      .border_color (border_color),
      .wr_en        (wr_en),
      .wr_idx       (wr_idx),
      .wr_data      (wr_data),
      .render_start (render_start),
      .render_line  (render_line),
      .vid_data     (vid_data),
      .vid_hsync    (vid_hsync),
      .vid_vsync    (vid_vsync),
      .vid_blank    (vid_blank)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: screen contents from the frame rules, outputs delayed 2 clocks.
   typedef struct {
      bit known;
      int data;
      bit hs;
      bit vs;
      bit bl;
   } vstage_t;

   logic [5:0] m_mem [512];
   bit         m_known [512];
   int         m_line = 0, m_wb = 0, m_md = 0, m_rl = 0;
   bit         m_rs = 0, m_valid = 0;
   vstage_t    m_s1, m_out;

   initial begin : model
      vstage_t nxt;
      int hsx, idx, addr, t, h;
      forever begin
         @(posedge clk);
         if (reset) begin
            nxt.known = 1; nxt.data = 0; nxt.hs = 1; nxt.vs = 1; nxt.bl = 1;
            m_out = nxt;
            m_s1  = nxt;
            m_rs  = 0;
            m_rl  = 0;
         end else begin
            m_out  = m_s1;
            h      = int'(hpos);
            hsx    = (m_md != 0) ? 64 : 96;
            nxt.hs = hsync; nxt.vs = vsync; nxt.bl = blank;
            if (blank) begin
               nxt.data = 0; nxt.known = 1;
            end else if (h >= hsx && h < hsx + 512) begin
               idx       = (h - hsx) / 2;
               addr      = (1 - m_wb) * 256 + idx;
               nxt.data  = int'(m_mem[addr]);
               nxt.known = m_known[addr];
            end else begin
               nxt.data = int'(border_color); nxt.known = 1;
            end
            m_s1 = nxt;
            m_rs = 0;
            if (vnext) begin
               t = m_line + 2;
               if (t >= 262) t -= 262;
               if (t < 240) begin
                  m_rs = 1;
                  m_rl = t;
               end
            end
         end
         if (wr_en) begin
            m_mem[m_wb * 256 + int'(wr_idx)]   = wr_data;
            m_known[m_wb * 256 + int'(wr_idx)] = 1;
         end
         if (reset) begin
            m_line = 0; m_wb = 0; m_md = 0;
         end else begin
            if (vnewframe) m_line = 240;
            else if (vnext) m_line = (m_line == 261) ? 0 : m_line + 1;
            if (vnext) begin
               m_wb = 1 - m_wb;
               m_md = mode;
            end
         end
         m_valid = 1;
      end
   end

   initial begin : compare
      forever begin
         @(negedge clk);
         if (m_valid) begin
            chk("vid_hsync", vid_hsync, m_out.hs);
            chk("vid_vsync", vid_vsync, m_out.vs);
            chk("vid_blank", vid_blank, m_out.bl);
            if (m_out.known) chk("vid_data", vid_data, m_out.data);
            chk("render_start", render_start, m_rs);
            chk("render_line", render_line, m_rl);
         end
      end
   end

   // Scanline driver; cap_* hold the output belonging to each hpos.
   int   wr_pat = 0, mode_at = -1, rst_at = -1;
   bit   mode_val = 0, coin_wr = 0, vs_low = 0;
   logic [5:0] cap_d [800];
   logic       cap_hs [800];
   logic       cap_bl [800];

   task automatic scanline(input int len, input bit second, input bit nf);
      logic [5:0] v;
      for (int h = 0; h < len; h++) begin
         hpos      = 10'(h);
         blank     = (h >= 704);
         hsync     = !(h >= 712 && h < 720);
         vsync     = !vs_low;
         vnext     = second && (h == len - 1);
         vnewframe = nf && !second && (h == 0);
         reset     = (rst_at >= 0) && (h >= rst_at) && (h < rst_at + 2);
         if (!second && h == mode_at) mode = mode_val;
         wr_en = 0; wr_idx = 0; wr_data = 0;
         if (wr_pat != 0 && !second && h < 256) begin
            v       = 6'(h);
            wr_en   = 1;
            wr_idx  = 8'(h);
            wr_data = (wr_pat == 1) ? v : ~v;
         end else if (coin_wr && second && h == len - 1) begin
            wr_en = 1; wr_idx = 8'd5; wr_data = 6'd7;
         end
         @(negedge clk);
         if (h > 0) begin
            cap_d[h-1]  = vid_data;
            cap_hs[h-1] = vid_hsync;
            cap_bl[h-1] = vid_blank;
         end
      end
   endtask

   task automatic src_line(input int len);
      scanline(len, 0, 0);
      scanline(len, 1, 0);
   endtask

   initial begin
      reset = 1; mode = 0; hpos = 0; hsync = 1; vsync = 1; blank = 1;
      vnext = 0; vnewframe = 0; border_color = 6'h2A;
      wr_en = 0; wr_idx = 0; wr_data = 0;
      repeat (3) @(negedge clk);
      chk("rst vid_data", vid_data, 0);
      chk("rst vid_hsync", vid_hsync, 1);
      chk("rst vid_vsync", vid_vsync, 1);
      chk("rst vid_blank", vid_blank, 1);
      chk("rst render_start", render_start, 0);
      chk("rst render_line", render_line, 0);

      // L0: vnewframe, fill bank 0 with idx[5:0]
      wr_pat = 1;
      scanline(800, 0, 1);
      wr_pat = 0;
      scanline(800, 1, 0);

      // L1: show bank 0, fill bank 1 with ~idx, mode request mid-line
      wr_pat = 2; mode_at = 300; mode_val = 1;
      scanline(800, 0, 0);
      wr_pat = 0; mode_at = -1;
      chk("l1 border 0", cap_d[0], 6'h2A);
      chk("l1 border 95", cap_d[95], 6'h2A);
      chk("l1 pix 96", cap_d[96], 0);
      chk("l1 pix 97", cap_d[97], 0);
      chk("l1 pix 98", cap_d[98], 1);
      chk("l1 pix 607", cap_d[607], 63);
      chk("l1 border 608", cap_d[608], 6'h2A);
      chk("l1 border 703", cap_d[703], 6'h2A);
      chk("l1 blank data", cap_d[750], 0);
      chk("l1 blank 703", cap_bl[703], 0);
      chk("l1 blank 704", cap_bl[704], 1);
      chk("l1 hsync 711", cap_hs[711], 1);
      chk("l1 hsync 712", cap_hs[712], 0);
      chk("l1 hsync 719", cap_hs[719], 0);
      chk("l1 hsync 720", cap_hs[720], 1);
      coin_wr = 1;
      scanline(800, 1, 0);
      coin_wr = 0;
      chk("l1b border 64", cap_d[64], 6'h2A);
      chk("l1b pix 96", cap_d[96], 0);
      chk("l1 no render", render_start, 0);

      // L2: mode 1 window, bank 1 incl. coincident write
      scanline(800, 0, 0);
      chk("l2 border 63", cap_d[63], 6'h2A);
      chk("l2 pix 64", cap_d[64], 63);
      chk("l2 pix 65", cap_d[65], 63);
      chk("l2 pix 66", cap_d[66], 62);
      chk("l2 coin 74", cap_d[74], 7);
      chk("l2 coin 75", cap_d[75], 7);
      chk("l2 pix 76", cap_d[76], 57);
      chk("l2 pix 575", cap_d[575], 0);
      chk("l2 border 576", cap_d[576], 6'h2A);
      scanline(800, 1, 0);

      // Line tracking across the frame wrap (q_line now 243)
      for (int i = 243; i < 260; i++) src_line(16);
      src_line(16);
      chk("q260 start", render_start, 1);
      chk("q260 line", render_line, 0);
      src_line(16);
      chk("q261 start", render_start, 1);
      chk("q261 line", render_line, 1);
      vs_low = 1;
      src_line(16);
      vs_low = 0;
      for (int i = 1; i < 236; i++) src_line(16);
      src_line(16);
      chk("q236 line", render_line, 238);
      src_line(16);
      chk("q237 start", render_start, 1);
      chk("q237 line", render_line, 239);
      src_line(16);
      chk("q238 start", render_start, 0);
      chk("q238 line", render_line, 239);
      src_line(16);
      chk("q239 start", render_start, 0);
      src_line(16);
      chk("q240 start", render_start, 0);
      chk("q240 line", render_line, 239);

      // Reset pulse mid-line, then resume at the next vnext
      rst_at = 300;
      scanline(800, 0, 0);
      rst_at = -1;
      chk("mid rst blank", cap_bl[299], 1);
      chk("mid rst data", cap_d[299], 0);
      chk("mid rst hsync", cap_hs[299], 1);
      chk("post rst blank 301", cap_bl[301], 1);
      chk("post rst blank 302", cap_bl[302], 0);
      chk("post rst pix 302", cap_d[302], 24);
      scanline(800, 1, 0);
      chk("post rst start", render_start, 1);
      chk("post rst line", render_line, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
